// File: rtl/mcu_pkg.sv
// Shared MCU constants: widths, opcode encodings and fixed instruction words.
// The fetch sequencer and the datapath decoder both import this package.
package mcu_pkg;

  localparam int PC_W        = 11;
  localparam int INSN_W      = 14;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W        = $clog2(STACK_DEPTH);
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

  localparam logic [PC_W-1:0]   RESET_VEC   = 11'h000;
  localparam logic [2:0]        OP_GOTO     = 3'b101;
  localparam logic [2:0]        OP_CALL     = 3'b100;
  localparam logic [INSN_W-1:0] INSN_RETURN = 14'h0008;
  localparam logic [INSN_W-1:0] INSN_NOP    = 14'h0000;

  typedef enum logic [1:0] {
    FLOW_HOLD = 2'd0,
    FLOW_SEQ  = 2'd1,
    FLOW_JUMP = 2'd2,
    FLOW_SKIP = 2'd3
  } flow_e;

  function automatic logic [2:0] insn_op(input logic [INSN_W-1:0] insn);
    return insn[INSN_W-1:INSN_W-3];
  endfunction

endpackage

// File: rtl/call_stack.sv
// Circular hardware return stack: the pointer marks the next free slot, so the
// top entry sits one below it. Overflow overwrites the oldest entry.
module call_stack
  import mcu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [PC_W-1:0]    push_addr_i,
  output logic [PC_W-1:0]    pop_addr_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               ovf_o,
  output logic               unf_o
);

  logic [PC_W-1:0]    mem_q [STACK_DEPTH];
  logic [SP_W-1:0]    ptr_q, ptr_d, ptr_dec_s;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic               full_s, empty_s;

  assign ptr_dec_s  = ptr_q - SP_W'(1);
  assign full_s     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty_s    = (depth_q == DEPTH_W'(0));
  assign pop_addr_o = mem_q[ptr_dec_s];
  assign depth_o    = depth_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

  // Pointer, depth and sticky flag next-state; depth saturates at both ends.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_i) begin
      ptr_d = ptr_q + SP_W'(1);
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + DEPTH_W'(1);
      end
    end else if (pop_i) begin
      ptr_d = ptr_dec_s;
      if (empty_s) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - DEPTH_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage needs no reset; an underflowing pop returns whatever is there.
  always_ff @(posedge clk) begin
    if (rst_n && push_i) begin
      mem_q[ptr_q] <= push_addr_i;
    end else begin
      mem_q[ptr_q] <= mem_q[ptr_q];
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, instruction register and flow-control priority logic.
// Taken GOTO/CALL/RETURN and datapath skips each cost exactly one bubble.
module fetch_sequencer
  import mcu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VEC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSN_W-1:0]  rom_data,
  input  logic               stall,
  input  logic               skip_req,
  output logic [INSN_W-1:0]  ir,
  output logic               ir_valid,
  output logic [PC_W-1:0]    ir_pc,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_ovf,
  output logic               stack_unf
);

  logic [PC_W-1:0]   pc_q, pc_d, ir_pc_q, ir_pc_d, pc_inc_s, target_s, pop_addr_s;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              is_goto_s, is_call_s, is_ret_s, is_flow_s, push_s, pop_s;
  flow_e             flow_s;

  assign pc_inc_s  = pc_q + PC_W'(1);
  assign is_goto_s = ir_valid_q && (insn_op(ir_q) == OP_GOTO);
  assign is_call_s = ir_valid_q && (insn_op(ir_q) == OP_CALL);
  assign is_ret_s  = ir_valid_q && (ir_q == INSN_RETURN);
  assign is_flow_s = is_goto_s || is_call_s || is_ret_s;
  assign target_s  = is_ret_s ? pop_addr_s : ir_q[PC_W-1:0];

  // Priority: stall, then control flow in ir, then a skip, then sequential fetch.
  always_comb begin
    flow_s = FLOW_SEQ;
    if (stall) begin
      flow_s = FLOW_HOLD;
    end else if (is_flow_s) begin
      flow_s = FLOW_JUMP;
    end else if (skip_req && ir_valid_q) begin
      flow_s = FLOW_SKIP;
    end else begin
      flow_s = FLOW_SEQ;
    end
  end

  assign push_s = (flow_s == FLOW_JUMP) && is_call_s;
  assign pop_s  = (flow_s == FLOW_JUMP) && is_ret_s;

  // Next-state for PC and the instruction register.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ir_pc_d    = ir_pc_q;
    case (flow_s)
      FLOW_HOLD: begin
        pc_d = pc_q;
      end
      FLOW_JUMP: begin
        pc_d       = target_s;
        ir_d       = INSN_NOP;
        ir_valid_d = 1'b0;
        ir_pc_d    = target_s;
      end
      FLOW_SKIP: begin
        pc_d       = pc_inc_s;
        ir_d       = INSN_NOP;
        ir_valid_d = 1'b0;
        ir_pc_d    = pc_q;
      end
      FLOW_SEQ: begin
        pc_d       = pc_inc_s;
        ir_d       = rom_data;
        ir_valid_d = 1'b1;
        ir_pc_d    = pc_q;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      ir_q       <= INSN_NOP;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= RESET_VECTOR;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  call_stack u_call_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_addr_i (pc_q),
    .pop_addr_o  (pop_addr_s),
    .depth_o     (stack_depth),
    .ovf_o       (stack_ovf),
    .unf_o       (stack_unf)
  );

  assign rom_addr = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign ir_pc    = ir_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural ROM.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        skip_req;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic [13:0] ir;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic [3:0]  stack_depth;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom_mem [0:2047];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .stall       (stall),
    .skip_req    (skip_req),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_pc       (ir_pc),
    .stack_depth (stack_depth),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always_comb rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default word at address a is 0b110 followed by a: never control flow, unique per address.
  task automatic rom_default();
    for (int a = 0; a < 2048; a++) begin
      logic [31:0] av;
      av = a;
      rom_mem[a] = {3'b110, av[10:0]};
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; skip_req = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rom_default();
    rst_n = 1'b0; stall = 1'b1; skip_req = 1'b1;
    step(); step();
    n_checks++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
    n_checks++; if (ir !== 14'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", ir); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
    n_checks++; if (ir_pc !== 11'h000) begin n_fail++; $display("FAIL reset_ir_pc: got %h want 000", ir_pc); end
    n_checks++; if (stack_depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", stack_depth); end
    n_checks++; if (stack_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", stack_ovf); end
    n_checks++; if (stack_unf !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b want 0", stack_unf); end
    stall = 1'b0; skip_req = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [13:0] words [4];
    words = '{14'h3004, 14'h008E, 14'h3000, 14'h00A5};
    for (int i = 0; i < 4; i++) rom_mem[i] = words[i];
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (ir_pc !== 11'(i)) begin n_fail++; $display("FAIL straight_ir_pc[%0d]: got %h want %h", i, ir_pc, 11'(i)); end
      n_checks++; if (ir !== words[i]) begin n_fail++; $display("FAIL straight_ir[%0d]: got %h want %h", i, ir, words[i]); end
      n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL straight_valid[%0d]: got %b want 1", i, ir_valid); end
      n_checks++; if (rom_addr !== 11'(i + 1)) begin n_fail++; $display("FAIL straight_rom_addr[%0d]: got %h want %h", i, rom_addr, 11'(i + 1)); end
    end
  endtask

  task automatic test_goto();
    logic seen7;
    rom_default();
    rom_mem[6] = 14'h2804;
    do_reset();
    repeat (7) step();
    n_checks++; if (ir !== 14'h2804 || ir_pc !== 11'h006) begin n_fail++; $display("FAIL goto_in_ir: got ir=%h pc=%h want ir=2804 pc=006", ir, ir_pc); end
    step();
    n_checks++; if (ir !== 14'h0000 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL goto_bubble: got ir=%h v=%b want ir=0000 v=0", ir, ir_valid); end
    n_checks++; if (ir_pc !== 11'h004 || rom_addr !== 11'h004) begin n_fail++; $display("FAIL goto_target: got ir_pc=%h rom_addr=%h want 004/004", ir_pc, rom_addr); end
    step();
    n_checks++; if (ir !== 14'h3004 || ir_pc !== 11'h004 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL goto_landing: got ir=%h pc=%h v=%b want 3004/004/1", ir, ir_pc, ir_valid); end
    seen7 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ir_valid === 1'b1 && ir_pc === 11'h007) seen7 = 1'b1;
    end
    n_checks++; if (seen7 !== 1'b0) begin n_fail++; $display("FAIL goto_shadow: got addr 7 executed=%b want 0", seen7); end
  endtask

  task automatic test_call_return();
    rom_default();
    rom_mem[0]     = 14'h2820;
    rom_mem[11'h020] = 14'h2010;
    rom_mem[11'h010] = 14'h0008;
    do_reset();
    step(); step(); step();
    n_checks++; if (ir !== 14'h2010 || stack_depth !== 4'd0) begin n_fail++; $display("FAIL call_in_ir: got ir=%h depth=%0d want 2010/0", ir, stack_depth); end
    step();
    n_checks++; if (ir_valid !== 1'b0 || ir_pc !== 11'h010 || stack_depth !== 4'd1) begin n_fail++; $display("FAIL call_bubble: got v=%b pc=%h depth=%0d want 0/010/1", ir_valid, ir_pc, stack_depth); end
    step();
    n_checks++; if (ir !== 14'h0008 || ir_pc !== 11'h010) begin n_fail++; $display("FAIL ret_in_ir: got ir=%h pc=%h want 0008/010", ir, ir_pc); end
    step();
    n_checks++; if (ir_valid !== 1'b0 || ir_pc !== 11'h021 || stack_depth !== 4'd0) begin n_fail++; $display("FAIL ret_bubble: got v=%b pc=%h depth=%0d want 0/021/0", ir_valid, ir_pc, stack_depth); end
    step();
    n_checks++; if (ir !== 14'h3021 || ir_pc !== 11'h021 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL ret_landing: got ir=%h pc=%h v=%b want 3021/021/1", ir, ir_pc, ir_valid); end
  endtask

  task automatic test_skip();
    rom_default();
    do_reset();
    repeat (6) step();
    n_checks++; if (ir_pc !== 11'h005) begin n_fail++; $display("FAIL skip_setup: got ir_pc=%h want 005", ir_pc); end
    skip_req = 1'b1;
    step();
    skip_req = 1'b0;
    n_checks++; if (ir_valid !== 1'b0 || ir !== 14'h0000) begin n_fail++; $display("FAIL skip_bubble: got v=%b ir=%h want 0/0000", ir_valid, ir); end
    step();
    n_checks++; if (ir_pc !== 11'h007 || ir !== 14'h3007 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL skip_next: got pc=%h ir=%h v=%b want 007/3007/1", ir_pc, ir, ir_valid); end
  endtask

  task automatic test_nested_calls();
    int exp_d;
    rom_default();
    rom_mem[0] = 14'h2900;
    for (int k = 0; k < 9; k++) begin
      rom_mem[11'(256 + 16 * k)] = 14'h2000 | 14'(256 + 16 * (k + 1));
      rom_mem[11'(257 + 16 * k)] = 14'h0008;
    end
    rom_mem[11'h190] = 14'h0008;
    do_reset();
    step(); step();
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++; if (ir_pc !== 11'(256 + 16 * k) || ir_valid !== 1'b1) begin n_fail++; $display("FAIL nest_call_pc[%0d]: got %h v=%b want %h", k, ir_pc, ir_valid, 11'(256 + 16 * k)); end
      step();
      exp_d = (k + 1 > 8) ? 8 : k + 1;
      n_checks++; if (stack_depth !== 4'(exp_d) || stack_ovf !== (k == 8)) begin n_fail++; $display("FAIL nest_call_depth[%0d]: got depth=%0d ovf=%b want %0d/%b", k, stack_depth, stack_ovf, exp_d, (k == 8)); end
    end
    for (int j = 1; j <= 9; j++) begin
      step();
      n_checks++; if (ir !== 14'h0008) begin n_fail++; $display("FAIL nest_ret_ir[%0d]: got %h want 0008", j, ir); end
      step();
      exp_d = (j <= 8) ? 8 - j : 0;
      n_checks++; if (stack_depth !== 4'(exp_d) || stack_unf !== (j == 9)) begin n_fail++; $display("FAIL nest_ret_depth[%0d]: got depth=%0d unf=%b want %0d/%b", j, stack_depth, stack_unf, exp_d, (j == 9)); end
      if (j <= 8) begin
        n_checks++; if (ir_pc !== 11'(257 + 16 * (9 - j))) begin n_fail++; $display("FAIL nest_ret_target[%0d]: got %h want %h", j, ir_pc, 11'(257 + 16 * (9 - j))); end
      end
    end
  endtask

  task automatic test_stall_wrap_reset();
    rom_default();
    rom_mem[0]       = 14'h2FFD;
    rom_mem[11'h7FF] = 14'h2000;
    do_reset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (ir !== 14'h2FFD || ir_pc !== 11'h000 || ir_valid !== 1'b1 || rom_addr !== 11'h001) begin n_fail++; $display("FAIL stall_hold[%0d]: got ir=%h pc=%h v=%b addr=%h want 2FFD/000/1/001", i, ir, ir_pc, ir_valid, rom_addr); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (ir_valid !== 1'b0 || ir_pc !== 11'h7FD || rom_addr !== 11'h7FD) begin n_fail++; $display("FAIL stall_goto: got v=%b pc=%h addr=%h want 0/7FD/7FD", ir_valid, ir_pc, rom_addr); end
    step(); step(); step();
    n_checks++; if (ir_pc !== 11'h7FF || ir !== 14'h2000 || rom_addr !== 11'h000) begin n_fail++; $display("FAIL pc_wrap: got pc=%h ir=%h addr=%h want 7FF/2000/000", ir_pc, ir, rom_addr); end
    step();
    n_checks++; if (ir_valid !== 1'b0 || stack_depth !== 4'd1) begin n_fail++; $display("FAIL wrap_call: got v=%b depth=%0d want 0/1", ir_valid, stack_depth); end
    rst_n = 1'b0; stall = 1'b1;
    step();
    n_checks++; if (ir !== 14'h0000 || ir_valid !== 1'b0 || ir_pc !== 11'h000 || rom_addr !== 11'h000) begin n_fail++; $display("FAIL bubble_reset: got ir=%h v=%b pc=%h addr=%h want 0000/0/000/000", ir, ir_valid, ir_pc, rom_addr); end
    n_checks++; if (stack_depth !== 4'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin n_fail++; $display("FAIL bubble_reset_stack: got depth=%0d ovf=%b unf=%b want 0/0/0", stack_depth, stack_ovf, stack_unf); end
    stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; skip_req = 1'b0;
    test_reset();
    test_straight_line();
    test_goto();
    test_call_return();
    test_skip();
    test_nested_calls();
    test_stall_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and program-flow controller for the MCU core. It owns the program counter and drives the address of the combinational program ROM. It captures each returned 14-bit word into an instruction register for the execute datapath. It resolves GOTO/CALL/RETURN and datapath skip requests with a one-cycle bubble, using an 8-level hardware return stack.

## Interface
- PC_W, 11, program counter / ROM address width
- INSN_W, 14, instruction width
- STACK_DEPTH, 8, return-stack entries (power of two)
- RESET_VECTOR, 0, PC value after reset

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- rom_addr  out  PC_W  ROM address, equals PC register
- rom_data  in  INSN_W  ROM word at rom_addr, same cycle (combinational ROM)
- stall  in  1  hold all state; no fetch, push or pop
- skip_req  in  1  datapath: discard instruction following the one in ir
- ir  out  INSN_W  instruction being executed this cycle
- ir_valid  out  1  ir holds a fetched instruction (0 = bubble NOP)
- ir_pc  out  PC_W  address of instruction in ir
- stack_depth  out  4  occupied entries, 0..STACK_DEPTH
- stack_ovf  out  1  sticky, push while full
- stack_unf  out  1  sticky, pop while empty

## Operation
- Pipeline: ir holds the instruction at A; PC = A+1; rom_data = ROM[A+1] is being fetched.
- Decode of ir (only when ir_valid=1):
  - GOTO: ir[13:11]=3'b101, target = ir[10:0]
  - CALL: ir[13:11]=3'b100, push PC (A+1), target = ir[10:0]
  - RETURN: ir=14'h0008, target = pop
- Each non-stalled cycle, in priority order:
  - Control-flow in ir: PC<=target, ir<=14'h0000, ir_valid<=0, ir_pc<=target.
  - skip_req & ir_valid & not control-flow: PC<=PC+1, ir<=14'h0000, ir_valid<=0.
  - Otherwise: ir<=rom_data, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
- skip_req is ignored when ir_valid=0 or ir is control-flow.
- PC increments modulo 2^PC_W: 11'h7FF -> 11'h000.
- Stack is a circular buffer with a 3-bit pointer and a depth counter 0..8.
  - Push at depth 8 overwrites the oldest entry; depth stays 8; sets stack_ovf.
  - Pop at depth 0 returns the entry under the pointer (stale data); depth stays 0; sets stack_unf.
  - Sticky flags clear only on reset.
- stall=1 freezes PC, ir, ir_valid, ir_pc, the stack and the flags. rom_addr stays stable.

## Timing
- Reset values: PC=RESET_VECTOR, rom_addr=RESET_VECTOR, ir=14'h0000, ir_valid=0, ir_pc=RESET_VECTOR, stack_depth=0, stack_ovf=0, stack_unf=0.
- First valid instruction appears in ir one cycle after rst_n rises.
- Straight-line code: one instruction per cycle.
- Taken GOTO/CALL/RETURN or skip: exactly one bubble cycle; the target instruction is in ir 2 cycles after the branch entered ir.
- rst_n=0 at any edge, including mid-stall or mid-bubble, overrides all other inputs, and the stack empties.
- Push and pop never occur in the same cycle, because at most one control-flow instruction is in ir.

## Structure
- Package mcu_pkg holds PC_W, INSN_W, STACK_DEPTH, OP_GOTO=3'b101, OP_CALL=3'b100, INSN_RETURN=14'h0008, INSN_NOP=14'h0000.
- The datapath decoder reuses these constants.
- Sub-module call_stack contains the storage, pointer, depth, push/pop ports and ovf/unf flags.
- fetch_sequencer holds the PC, ir and the priority logic.

## Test plan
- Reset then straight-line code with ROM 0..3 = 3004, 008E, 3000, 00A5: ir_pc sequence 0,1,2,3, ir_valid=1 from the 2nd cycle, rom_addr leads ir_pc by 1.
- GOTO 14'h2804 at address 6: next cycle ir=0000 with ir_valid=0, then ir=ROM[4] with ir_pc=4; ROM[7] never enters ir.
- CALL 14'h2010 at 0x020, RETURN at 0x010: stack_depth 0->1->0; the instruction after the return bubble has ir_pc=0x021.
- skip_req pulsed while ir_pc=5: the address-6 instruction is replaced by a bubble, and the next ir_pc=7.
- 9 nested CALLs: stack_ovf=1 after the 9th, depth=8. Then 9 RETURNs: stack_unf=1 on the 9th. The 8th return goes to the 2nd call's return address.
- Two-cycle stall on a GOTO, PC at 0x7FF wrap, and rst_n low during a bubble: all state frozen during the stall, then branch taken; PC wraps to 0x000; reset values on the next edge.
